simd_mac_array: RTL and testbench

- Parameterised successor to the single INT8 MAC: LANES parallel multiply-accumulate lanes sharing one valid/ready input stream.
- Two-stage pipeline: registered multiply, then accumulate.
- Dot-product framing via in_last. The result is emitted on a valid/ready output with backpressure, and the accumulators restart for back-to-back vectors.
- Sits between the NPU operand fetch and the requantisation/writeback stage.

---
 rtl/npu_mac_pkg.sv | 37 +++
 rtl/simd_mac_array_if.sv | 37 +++
 rtl/mac_lane.sv | 84 ++++++++
 rtl/simd_mac_array.sv | 115 +++++++++++
 tb/tb_simd_mac_array.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_mac_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | npu_mac_pkg : shared constants, operand mode and saturation helper      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package npu_mac_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    MAC_UNSIGNED = 1'b0,
    MAC_SIGNED   = 1'b1
  } mac_mode_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Classifies an (ACC_W+1)-bit extended sum by its two top bits, so it works at any width.
  function automatic sat_e sat_add_kind(input mac_mode_e mode, input logic carry, input logic msb);
    sat_e kind;
    kind = SAT_NONE;
    if (mode == MAC_SIGNED) begin
      if (carry != msb) kind = carry ? SAT_LO : SAT_HI;
    end else if (carry) begin
      kind = SAT_HI;
    end
    return kind;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simd_mac_array_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | simd_mac_array_if : operand stream in, dot-product results out          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface simd_mac_array_if
  import npu_mac_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic                      clear;
  logic                      signed_mode;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [LANES*DATA_W-1:0]   weight;
  logic [LANES*DATA_W-1:0]   activation;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*ACC_W-1:0]    out_data;
  logic [CNT_W-1:0]          out_count;
  logic [LANES-1:0]          out_ovf;

  modport master (
    output clear, signed_mode, in_valid, in_last, weight, activation, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  clear, signed_mode, in_valid, in_last, weight, activation, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mac_lane : one lane - product register, accumulator, sticky overflow    |
// | Optional saturation: SIMD_MAC_SAT_EN.  Rev 1.0                          |
// +-------------------------------------------------------------------------+
module mac_lane
  import npu_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              step_i,
  input  logic              last_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic [DATA_W-1:0] act_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    prod_d, prod_q;
  mac_mode_e        mode_q;
  logic [ACC_W-1:0] acc_q;
  logic             w_ext, a_ext, p_ext;

  // Extending both operands to PW bits lets one unsigned multiplier serve both modes.
  assign w_ext  = signed_i & weight_i[DATA_W-1];
  assign a_ext  = signed_i & act_i[DATA_W-1];
  assign prod_d = {{DATA_W{w_ext}}, weight_i} * {{DATA_W{a_ext}}, act_i};
  assign p_ext  = (mode_q == MAC_SIGNED) & prod_q[PW-1];

`ifdef SIMD_MAC_SAT_EN
  logic [ACC_W:0] wide_sum;
  sat_e           sat_kind;
  logic           ovf_q;

  assign wide_sum = (ACC_W+1)'($signed({p_ext, prod_q}))
                  + {(mode_q == MAC_SIGNED) & acc_q[ACC_W-1], acc_q};

  always_comb begin
    sat_kind = sat_add_kind(mode_q, wide_sum[ACC_W], wide_sum[ACC_W-1]);
    sum_o    = wide_sum[ACC_W-1:0];
    case (sat_kind)
      SAT_HI:  sum_o = (mode_q == MAC_SIGNED) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
      SAT_LO:  sum_o = {1'b1, {(ACC_W-1){1'b0}}};
      default: sum_o = wide_sum[ACC_W-1:0];
    endcase
    ovf_o = ovf_q | (sat_kind != SAT_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ovf_q <= 1'b0;
    else if (clear_i)         ovf_q <= 1'b0;
    else if (step_i)          ovf_q <= last_i ? 1'b0 : ovf_o;
  end
`else
  assign sum_o = acc_q + ACC_W'($signed({p_ext, prod_q}));
  assign ovf_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      mode_q <= MAC_UNSIGNED;
      acc_q  <= '0;
    end else if (clear_i) begin
      prod_q <= '0;
      mode_q <= MAC_UNSIGNED;
      acc_q  <= '0;
    end else begin
      if (accept_i) begin
        prod_q <= prod_d;
        mode_q <= mac_mode_e'(signed_i);
      end
      if (step_i) acc_q <= last_i ? '0 : sum_o;
    end
  end
endmodule
`default_nettype wire

// File: rtl/simd_mac_array.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | simd_mac_array : LANES-wide two-stage MAC with framed dot-product output|
// | Optional saturation: SIMD_MAC_SAT_EN.  Rev 1.0                          |
// +-------------------------------------------------------------------------+
module simd_mac_array
  import npu_mac_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  simd_mac_array_if.slave mac_if
);
  logic                   stall, accept, step;
  logic                   p_valid_q, p_valid_d, p_last_q, p_last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*ACC_W-1:0] out_data_q, out_data_d, lane_sum;
  logic [CNT_W-1:0]       out_count_q, out_count_d;
  logic [LANES-1:0]       out_ovf_q, out_ovf_d, lane_ovf;

  assign stall   = out_valid_q & ~mac_if.out_ready;
  assign accept  = mac_if.in_valid & ~stall & ~mac_if.clear;
  assign step    = p_valid_q & ~stall & ~mac_if.clear;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign mac_if.in_ready  = ~stall;
  assign mac_if.out_valid = out_valid_q;
  assign mac_if.out_data  = out_data_q;
  assign mac_if.out_count = out_count_q;
  assign mac_if.out_ovf   = out_ovf_q;

  always_comb begin
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (mac_if.clear) begin
      p_valid_d   = 1'b0;
      p_last_d    = 1'b0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_count_d = '0;
      out_ovf_d   = '0;
    end else begin
      if (accept) begin
        p_valid_d = 1'b1;
        p_last_d  = mac_if.in_last;
      end else if (!stall) begin
        p_valid_d = 1'b0;
      end
      if (out_valid_q && mac_if.out_ready) out_valid_d = 1'b0;
      // A result landing on the handshake cycle overrides the drop above.
      if (step) begin
        if (p_last_q) begin
          out_valid_d = 1'b1;
          out_data_d  = lane_sum;
          out_count_d = cnt_inc;
          out_ovf_d   = lane_ovf;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (mac_if.clear),
      .accept_i (accept),
      .step_i   (step),
      .last_i   (p_last_q),
      .signed_i (mac_if.signed_mode),
      .weight_i (mac_if.weight[i*DATA_W +: DATA_W]),
      .act_i    (mac_if.activation[i*DATA_W +: DATA_W]),
      .sum_o    (lane_sum[i*ACC_W +: ACC_W]),
      .ovf_o    (lane_ovf[i])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_simd_mac_array.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_simd_mac_array : table vectors, directed corners, random scoreboard  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_simd_mac_array;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  localparam int ACC16  = 16;
  localparam longint MOD = 64'sd1 << ACC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_mac_array_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  simd_mac_array_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC16), .CNT_W(CNT_W)) bus16 ();

  simd_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .mac_if(bus));
  simd_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC16), .CNT_W(CNT_W)) u_dut16 (
    .clk(clk), .rst(rst), .mac_if(bus16));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] a,
                       input logic last, input logic sgn);
    bus.in_valid    = 1'b1;
    bus.in_last     = last;
    bus.signed_mode = sgn;
    bus.weight      = {LANES{w}};
    bus.activation  = {LANES{a}};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int g;
    g = 0;
    while (!bus.out_valid && g < 20) begin
      tick();
      g++;
    end
    check(name, bus.out_valid, 1'b1);
  endtask

  // Reference model: mathematical per-lane sums, clamped or reduced mod 2^ACC_W.
  typedef struct {
    logic [LANES*ACC_W-1:0] d;
    logic [CNT_W-1:0]       c;
    logic [LANES-1:0]       o;
  } res_t;

  res_t             exp_q[$];
  res_t             r_mon;
  longint           m_acc[LANES];
  int               m_cnt;
  logic [LANES-1:0] m_ovf;
  longint           v, p, s, lo, hi;
  logic [7:0]       bw, ba;

  always @(negedge clk) begin
    if (rst || bus.clear) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = '0;
      for (int l = 0; l < LANES; l++) m_acc[l] = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 128'(exp_q.size()), 128'd1);
        end else begin
          r_mon = exp_q.pop_front();
          check("sb_data", bus.out_data, r_mon.d);
          check("sb_count", bus.out_count, r_mon.c);
          check("sb_ovf", bus.out_ovf, r_mon.o);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int l = 0; l < LANES; l++) begin
          bw = bus.weight[l*DATA_W +: DATA_W];
          ba = bus.activation[l*DATA_W +: DATA_W];
          p  = bus.signed_mode ? longint'($signed(bw)) * longint'($signed(ba))
                               : longint'(bw) * longint'(ba);
          v  = (bus.signed_mode && m_acc[l] >= (MOD / 2)) ? m_acc[l] - MOD : m_acc[l];
          s  = v + p;
`ifdef SIMD_MAC_SAT_EN
          lo = bus.signed_mode ? -(MOD / 2) : 0;
          hi = bus.signed_mode ? (MOD / 2) - 1 : MOD - 1;
          if (s > hi) begin s = hi; m_ovf[l] = 1'b1; end
          if (s < lo) begin s = lo; m_ovf[l] = 1'b1; end
`endif
          s = s % MOD;
          if (s < 0) s = s + MOD;
          m_acc[l] = s;
        end
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (bus.in_last) begin
          for (int l = 0; l < LANES; l++) r_mon.d[l*ACC_W +: ACC_W] = m_acc[l][ACC_W-1:0];
          r_mon.c = CNT_W'(m_cnt);
          r_mon.o = m_ovf;
          exp_q.push_back(r_mon);
          m_cnt = 0;
          m_ovf = '0;
          for (int l = 0; l < LANES; l++) m_acc[l] = 0;
        end
      end
    end
  end

  typedef struct {
    logic                sgn;
    logic [DATA_W-1:0]   w;
    logic [DATA_W-1:0]   a;
    int                  beats;
    logic [ACC_W-1:0]    exp_d;
    logic [CNT_W-1:0]    exp_c;
  } vec_t;

  typedef struct {
    logic [LANES*DATA_W-1:0] w;
    logic [LANES*DATA_W-1:0] a;
    logic                    last;
    logic                    sgn;
  } beat_t;

  vec_t                   tbl[6];
  beat_t                  bq[$];
  beat_t                  bt;
  logic [LANES*ACC_W-1:0] exp_vec;
  logic [LANES*ACC16-1:0] exp16;
  logic [LANES-1:0]       exp_ovf16;
  int                     guard, len;
  logic                   vsgn;

  initial begin
    tbl[0] = '{1'b1, 8'd3,   8'hFE, 3, 32'hFFFF_FFEE, 16'd3};
    tbl[1] = '{1'b0, 8'd255, 8'd255, 1, 32'd65025,     16'd1};
    tbl[2] = '{1'b1, 8'd255, 8'd255, 1, 32'd1,         16'd1};
    tbl[3] = '{1'b0, 8'd10,  8'd20,  4, 32'd800,       16'd4};
    tbl[4] = '{1'b1, 8'h80,  8'h80,  2, 32'd32768,     16'd2};
    tbl[5] = '{1'b1, 8'd127, 8'h80,  1, 32'hFFFF_C080, 16'd1};

    bus.clear = 0; bus.signed_mode = 0; bus.in_valid = 0; bus.in_last = 0;
    bus.weight = '0; bus.activation = '0; bus.out_ready = 1;
    bus16.clear = 0; bus16.signed_mode = 0; bus16.in_valid = 0; bus16.in_last = 0;
    bus16.weight = '0; bus16.activation = '0; bus16.out_ready = 1;

    tick(); tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_count", bus.out_count, '0);
    check("rst_out_ovf", bus.out_ovf, '0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Table vectors: uniform operands in all lanes, out_ready held high.
    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < tbl[t].beats; b++) begin
        drive(tbl[t].w, tbl[t].a, b == tbl[t].beats - 1, tbl[t].sgn);
        tick();
      end
      idle();
      check($sformatf("tbl%0d_lat_n1", t), bus.out_valid, 1'b0);
      tick();
      check($sformatf("tbl%0d_lat_n2", t), bus.out_valid, 1'b1);
      exp_vec = {LANES{tbl[t].exp_d}};
      check($sformatf("tbl%0d_data", t), bus.out_data, exp_vec);
      check($sformatf("tbl%0d_count", t), bus.out_count, tbl[t].exp_c);
      check($sformatf("tbl%0d_ovf", t), bus.out_ovf, '0);
      tick();
    end

    // Back-to-back vectors with the first result held under backpressure.
    bus.out_ready = 0;
    drive(8'd1, 8'd1, 1'b0, 1'b0); tick();
    drive(8'd1, 8'd1, 1'b1, 1'b0); tick();
    drive(8'd2, 8'd2, 1'b0, 1'b0); tick();
    drive(8'd2, 8'd2, 1'b1, 1'b0);
    exp_vec = {LANES{32'd2}};
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready_low", bus.in_ready, 1'b0);
      check("bp_data_stable", bus.out_data, exp_vec);
      check("bp_count_stable", bus.out_count, 16'd2);
      tick();
    end
    bus.out_ready = 1;
    tick();
    idle();
    wait_out("bp_second_wait");
    exp_vec = {LANES{32'd8}};
    check("bp_second_data", bus.out_data, exp_vec);
    check("bp_second_count", bus.out_count, 16'd2);
    tick();

    // clear mid-vector; the beat presented with clear must vanish.
    drive(8'd7, 8'd7, 1'b0, 1'b1); tick();
    drive(8'd7, 8'd7, 1'b0, 1'b1); tick();
    drive(8'd9, 8'd9, 1'b1, 1'b1);
    bus.clear = 1;
    tick();
    bus.clear = 0;
    idle();
    tick();
    check("clr_no_out_a", bus.out_valid, 1'b0);
    tick();
    check("clr_no_out_b", bus.out_valid, 1'b0);
    drive(8'd5, 8'd5, 1'b1, 1'b0); tick();
    idle();
    wait_out("clr_fresh_wait");
    exp_vec = {LANES{32'd25}};
    check("clr_fresh_data", bus.out_data, exp_vec);
    check("clr_fresh_count", bus.out_count, 16'd1);
    tick();

    // 16-bit accumulator: 3 x 127*127 = 48387 exceeds the signed range.
`ifdef SIMD_MAC_SAT_EN
    exp16     = {LANES{16'h7FFF}};
    exp_ovf16 = 4'b1111;
`else
    exp16     = {LANES{16'hBD03}};
    exp_ovf16 = 4'b0000;
`endif
    for (int b = 0; b < 3; b++) begin
      bus16.in_valid    = 1'b1;
      bus16.in_last     = (b == 2);
      bus16.signed_mode = 1'b1;
      bus16.weight      = {LANES{8'd127}};
      bus16.activation  = {LANES{8'd127}};
      tick();
    end
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
    guard = 0;
    while (!bus16.out_valid && guard < 20) begin tick(); guard++; end
    check("acc16_wait", bus16.out_valid, 1'b1);
    check("acc16_data", bus16.out_data, exp16);
    check("acc16_count", bus16.out_count, 16'd3);
    check("acc16_ovf", bus16.out_ovf, exp_ovf16);
    tick();

    // Randomised vectors, gaps and backpressure, checked by the scoreboard.
    for (int n = 0; n < 30; n++) begin
      len  = $urandom_range(1, 6);
      vsgn = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        bt.w    = $urandom;
        bt.a    = $urandom;
        bt.last = (b == len - 1);
        bt.sgn  = vsgn;
        bq.push_back(bt);
      end
    end
    guard = 0;
    while (bq.size() > 0 && guard < 5000) begin
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_last     = bq[0].last;
      bus.signed_mode = bq[0].sgn;
      bus.weight      = bq[0].w;
      bus.activation  = bq[0].a;
      #1;
      if (bus.in_valid && bus.in_ready) void'(bq.pop_front());
      @(posedge clk);
      #1;
      guard++;
    end
    check("rand_within_budget", guard < 5000, 1'b1);
    idle();
    bus.out_ready = 1;
    repeat (6) tick();
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset while a result is held.
    bus.out_ready = 0;
    drive(8'd3, 8'd3, 1'b1, 1'b0); tick();
    idle();
    wait_out("rst_hold_wait");
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data", bus.out_data, '0);
    check("arst_out_count", bus.out_count, '0);
    check("arst_out_ovf", bus.out_ovf, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    tick();
    check("arst_no_out", bus.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
`default_nettype wire
